lsu_ctrl: RTL and testbench

//   Load/store control stage between the core's MEM pipeline stage and the byte-enabled data memory.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 25 ++
 rtl/lsu_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store control stage: access lengths,
// RISC-V exception cause codes and the controller state encoding.
package lsu_pkg;

  localparam logic [1:0] LEN_BYTE    = 2'b00;
  localparam logic [1:0] LEN_HALF    = 2'b01;
  localparam logic [1:0] LEN_WORD    = 2'b10;
  localparam logic [1:0] LEN_ILLEGAL = 2'b11;

  localparam logic [3:0] CAUSE_NONE        = 4'd0;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACCESS   = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACCESS   = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACCESS   = 3'd1,
    ST_RESP     = 3'd2,
    ST_SPLIT_LO = 3'd3,
    ST_SPLIT_HI = 3'd4
  } lsu_state_e;

  // Cause code for a rejected request: access faults outrank misalignment.
  function automatic logic [3:0] faultCause(input logic isStore, input logic isAccess);
    if (isAccess) return isStore ? CAUSE_ST_ACCESS : CAUSE_LD_ACCESS;
    return isStore ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Extracts a misaligned load result from two consecutive memory words:
// shift the 7-byte window right by the byte offset, then mask and sign-extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [55:0] data_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  len_i,
  input  logic        sign_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = data_i[{off_i, 3'b000} +: 32];
    result_o = shifted;
    case (len_i)
      LEN_BYTE: result_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
      LEN_HALF: result_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
      default:  result_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage: one request per handshake, alignment/range checks,
// one-cycle memory access and a held response. Macro LSU_MISALIGN_SPLIT_EN adds split misaligned loads.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDRW = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic             req_sign_i,
  input  logic [1:0]       req_len_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [31:0]      resp_rdata_o,
  output logic             resp_exc_o,
  output logic [3:0]       resp_cause_o,
  output logic             mem_we_o,
  output logic             mem_sign_o,
  output logic [1:0]       mem_length_o,
  output logic [ADDRW-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  lsu_state_e       state_q;
  logic             we_q;
  logic             sign_q;
  logic [1:0]       len_q;
  logic [ADDRW-1:0] addr_q;
  logic [31:0]      wdata_q;
  logic             respValid_q;
  logic             respExc_q;
  logic [3:0]       respCause_q;
  logic [31:0]      respRdata_q;

  lsu_state_e       acceptState_d;
  logic             acceptExc_d;
  logic [3:0]       acceptCause_d;
  logic             rangeFault;
  logic             misaligned;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0]      splitLo_q;
  logic [31:0]      splitResult;

  lsu_align u_align (
    .data_i   ({mem_rdata_i[23:0], splitLo_q}),
    .off_i    (addr_q[1:0]),
    .len_i    (len_q),
    .sign_i   (sign_q),
    .result_o (splitResult)
  );
`endif

  // Classification of the request on offer; used only when it is accepted in IDLE.
  always_comb begin
    rangeFault    = (req_len_i == LEN_ILLEGAL) || (req_addr_i[31:ADDRW] != '0);
    misaligned    = ((req_len_i == LEN_HALF) && req_addr_i[0]) ||
                    ((req_len_i == LEN_WORD) && (req_addr_i[1:0] != 2'b00));
    acceptState_d = ST_ACCESS;
    acceptExc_d   = 1'b0;
    acceptCause_d = CAUSE_NONE;
    if (rangeFault) begin
      acceptState_d = ST_RESP;
      acceptExc_d   = 1'b1;
      acceptCause_d = faultCause(req_we_i, 1'b1);
    end else if (misaligned) begin
      acceptState_d = ST_RESP;
      acceptExc_d   = 1'b1;
      acceptCause_d = faultCause(req_we_i, 1'b0);
`ifdef LSU_MISALIGN_SPLIT_EN
      // The second word must exist: the top word of memory cannot be split.
      if (!req_we_i && (&req_addr_i[ADDRW-1:2])) begin
        acceptCause_d = CAUSE_LD_ACCESS;
      end else if (!req_we_i) begin
        acceptState_d = ST_SPLIT_LO;
        acceptExc_d   = 1'b0;
        acceptCause_d = CAUSE_NONE;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      sign_q      <= 1'b0;
      len_q       <= LEN_BYTE;
      addr_q      <= '0;
      wdata_q     <= '0;
      respValid_q <= 1'b0;
      respExc_q   <= 1'b0;
      respCause_q <= CAUSE_NONE;
      respRdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      splitLo_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            sign_q      <= req_sign_i;
            len_q       <= req_len_i;
            addr_q      <= req_addr_i[ADDRW-1:0];
            wdata_q     <= req_wdata_i;
            respExc_q   <= acceptExc_d;
            respCause_q <= acceptCause_d;
            respRdata_q <= '0;
            respValid_q <= (acceptState_d == ST_RESP);
            state_q     <= acceptState_d;
          end
        end
        ST_ACCESS: begin
          respRdata_q <= we_q ? 32'd0 : mem_rdata_i;
          respValid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ST_SPLIT_LO: begin
          splitLo_q <= mem_rdata_i;
          state_q   <= ST_SPLIT_HI;
        end
        ST_SPLIT_HI: begin
          respRdata_q <= splitResult;
          respValid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (resp_ready_i) begin
            respValid_q <= 1'b0;
            respExc_q   <= 1'b0;
            respCause_q <= CAUSE_NONE;
            respRdata_q <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory port is decoded from the state; split reads fetch whole words unsigned.
  always_comb begin
    mem_we_o     = we_q && (state_q == ST_ACCESS) && !rst_i;
    mem_sign_o   = sign_q;
    mem_length_o = len_q;
    mem_wdata_o  = wdata_q;
    mem_addr_o   = '0;
    case (state_q)
      ST_ACCESS: mem_addr_o = addr_q;
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_SPLIT_LO: begin
        mem_addr_o   = {addr_q[ADDRW-1:2], 2'b00};
        mem_length_o = LEN_WORD;
        mem_sign_o   = 1'b0;
      end
      ST_SPLIT_HI: begin
        mem_addr_o   = {addr_q[ADDRW-1:2] + 1'b1, 2'b00};
        mem_length_o = LEN_WORD;
        mem_sign_o   = 1'b0;
      end
`endif
      default: mem_addr_o = '0;
    endcase
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = respValid_q;
  assign resp_exc_o   = respExc_q;
  assign resp_cause_o = respCause_q;
  assign resp_rdata_o = respRdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a byte-addressed memory model.
// Split-load vectors are selected when LSU_MISALIGN_SPLIT_EN is defined.
module tb_lsu_ctrl;

  localparam int ADDRW = 12;

  logic             clk;
  logic             rst;
  logic             reqValid;
  logic             reqReady;
  logic             reqWe;
  logic             reqSign;
  logic [1:0]       reqLen;
  logic [31:0]      reqAddr;
  logic [31:0]      reqWdata;
  logic             respValid;
  logic             respReady;
  logic [31:0]      respRdata;
  logic             respExc;
  logic [3:0]       respCause;
  logic             memWe;
  logic             memSign;
  logic [1:0]       memLength;
  logic [ADDRW-1:0] memAddr;
  logic [31:0]      memWdata;
  logic [31:0]      memRdata;

  logic [7:0]       memArray [0:(1<<ADDRW)-1];
  logic             memClear;
  logic [7:0]       b0, b1, b2, b3;
  int               weCount;
  int               memCycleCount;
  int               checks;
  int               errors;

  lsu_ctrl #(.ADDRW(ADDRW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (reqValid),
    .req_ready_o  (reqReady),
    .req_we_i     (reqWe),
    .req_sign_i   (reqSign),
    .req_len_i    (reqLen),
    .req_addr_i   (reqAddr),
    .req_wdata_i  (reqWdata),
    .resp_valid_o (respValid),
    .resp_ready_i (respReady),
    .resp_rdata_o (respRdata),
    .resp_exc_o   (respExc),
    .resp_cause_o (respCause),
    .mem_we_o     (memWe),
    .mem_sign_o   (memSign),
    .mem_length_o (memLength),
    .mem_addr_o   (memAddr),
    .mem_wdata_o  (memWdata),
    .mem_rdata_i  (memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian combinational read port with length and sign handling.
  always_comb begin
    b0 = memArray[memAddr];
    b1 = memArray[memAddr + 12'd1];
    b2 = memArray[memAddr + 12'd2];
    b3 = memArray[memAddr + 12'd3];
    case (memLength)
      2'b00:   memRdata = {{24{memSign & b0[7]}}, b0};
      2'b01:   memRdata = {{16{memSign & b1[7]}}, b1, b0};
      default: memRdata = {b3, b2, b1, b0};
    endcase
  end

  // Byte-enabled write port plus counters of write cycles and addressed cycles.
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < (1 << ADDRW); i++) memArray[i] <= 8'h00;
    end else if (memWe) begin
      memArray[memAddr] <= memWdata[7:0];
      if (memLength != 2'b00) memArray[memAddr + 12'd1] <= memWdata[15:8];
      if (memLength == 2'b10) begin
        memArray[memAddr + 12'd2] <= memWdata[23:16];
        memArray[memAddr + 12'd3] <= memWdata[31:24];
      end
    end
    if (memWe) weCount <= weCount + 1;
    if (memAddr != '0) memCycleCount <= memCycleCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One full request/response; holdCycles > 0 keeps resp_ready low that long.
  task automatic applyStimulus(input string tag, input logic we, input logic sign,
                               input logic [1:0] len, input logic [31:0] addr,
                               input logic [31:0] wdata, input int holdCycles,
                               input logic [31:0] expRdata, input logic expExc,
                               input logic [3:0] expCause, input int expLat,
                               input int expMemCycles);
    int guard;
    int lat;
    int weBefore;
    int mcBefore;
    @(negedge clk);
    guard = 0;
    while (!reqReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, ".reqReady"}, {31'd0, reqReady}, 32'd1);
    weBefore  = weCount;
    mcBefore  = memCycleCount;
    respReady = (holdCycles == 0);
    reqValid  = 1'b1;
    reqWe     = we;
    reqSign   = sign;
    reqLen    = len;
    reqAddr   = addr;
    reqWdata  = wdata;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    lat = 1;
    while (!respValid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, ".latency"}, lat, expLat);
    checkOutput({tag, ".rdata"}, respRdata, expRdata);
    checkOutput({tag, ".exc"}, {31'd0, respExc}, {31'd0, expExc});
    checkOutput({tag, ".cause"}, {28'd0, respCause}, {28'd0, expCause});
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, ".holdValid"}, {31'd0, respValid}, 32'd1);
      checkOutput({tag, ".holdRdata"}, respRdata, expRdata);
      checkOutput({tag, ".holdReqReady"}, {31'd0, reqReady}, 32'd0);
    end
    respReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, ".respDropped"}, {31'd0, respValid}, 32'd0);
    checkOutput({tag, ".memCycles"}, memCycleCount - mcBefore, expMemCycles);
    checkOutput({tag, ".writes"}, weCount - weBefore, (we && expMemCycles != 0) ? 1 : 0);
  endtask

  initial begin
    int weBefore;
    checks        = 0;
    errors        = 0;
    weCount       = 0;
    memCycleCount = 0;
    rst       = 1'b1;
    memClear  = 1'b1;
    reqValid  = 1'b0;
    reqWe     = 1'b0;
    reqSign   = 1'b0;
    reqLen    = 2'b00;
    reqAddr   = 32'd0;
    reqWdata  = 32'd0;
    respReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    memClear = 1'b0;
    #1;
    checkOutput("reset.reqReady", {31'd0, reqReady}, 32'd1);
    checkOutput("reset.respValid", {31'd0, respValid}, 32'd0);
    checkOutput("reset.respExc", {31'd0, respExc}, 32'd0);
    checkOutput("reset.respRdata", respRdata, 32'd0);
    checkOutput("reset.respCause", {28'd0, respCause}, 32'd0);
    checkOutput("reset.memWe", {31'd0, memWe}, 32'd0);
    checkOutput("reset.memAddr", {20'd0, memAddr}, 32'd0);

    // Aligned store/load round trip and byte access with sign handling.
    applyStimulus("SW100", 1'b1, 1'b0, 2'b10, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1'b0, 4'd0, 2, 1);
    applyStimulus("LW100", 1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, 4'd0, 2, 1);
    applyStimulus("SB103", 1'b1, 1'b0, 2'b00, 32'h103, 32'h00000080, 0, 32'h0, 1'b0, 4'd0, 2, 1);
    applyStimulus("LB103", 1'b0, 1'b1, 2'b00, 32'h103, 32'h0, 0, 32'hFFFFFF80, 1'b0, 4'd0, 2, 1);
    applyStimulus("LBU103", 1'b0, 1'b0, 2'b00, 32'h103, 32'h0, 0, 32'h00000080, 1'b0, 4'd0, 2, 1);
    applyStimulus("LW100b", 1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 0, 32'h80ADBEEF, 1'b0, 4'd0, 2, 1);

`ifdef LSU_MISALIGN_SPLIT_EN
    applyStimulus("LH101split", 1'b0, 1'b0, 2'b01, 32'h101, 32'h0, 0, 32'h0000ADBE, 1'b0, 4'd0, 3, 2);
    applyStimulus("LWFFE", 1'b0, 1'b0, 2'b10, 32'hFFE, 32'h0, 0, 32'h0, 1'b1, 4'd5, 1, 0);
`else
    applyStimulus("LH101", 1'b0, 1'b0, 2'b01, 32'h101, 32'h0, 0, 32'h0, 1'b1, 4'd4, 1, 0);
    applyStimulus("LWFFE", 1'b0, 1'b0, 2'b10, 32'hFFE, 32'h0, 0, 32'h0, 1'b1, 4'd4, 1, 0);
`endif

    // Range, illegal-length and store-misalign faults never touch memory.
    applyStimulus("SW1000", 1'b1, 1'b0, 2'b10, 32'h1000, 32'h12345678, 0, 32'h0, 1'b1, 4'd7, 1, 0);
    applyStimulus("LEN11", 1'b0, 1'b0, 2'b11, 32'h10, 32'h0, 0, 32'h0, 1'b1, 4'd5, 1, 0);
    applyStimulus("SH201", 1'b1, 1'b0, 2'b01, 32'h201, 32'hBEEF, 0, 32'h0, 1'b1, 4'd6, 1, 0);

    applyStimulus("LWhold", 1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 5, 32'h80ADBEEF, 1'b0, 4'd0, 2, 1);

    // A store caught by reset in its ACCESS cycle must not reach memory.
    applyStimulus("SW200", 1'b1, 1'b0, 2'b10, 32'h200, 32'h11223344, 0, 32'h0, 1'b0, 4'd0, 2, 1);
    @(negedge clk);
    weBefore = weCount;
    reqValid = 1'b1;
    reqWe    = 1'b1;
    reqSign  = 1'b0;
    reqLen   = 2'b10;
    reqAddr  = 32'h200;
    reqWdata = 32'h00000055;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    checkOutput("rstAccess.memWeArmed", {31'd0, memWe}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstAccess.memWeGated", {31'd0, memWe}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rstAccess.reqReady", {31'd0, reqReady}, 32'd1);
    checkOutput("rstAccess.respValid", {31'd0, respValid}, 32'd0);
    checkOutput("rstAccess.writes", weCount - weBefore, 32'd0);
    applyStimulus("LW200", 1'b0, 1'b0, 2'b10, 32'h200, 32'h0, 0, 32'h11223344, 1'b0, 4'd0, 2, 1);

`ifdef LSU_MISALIGN_SPLIT_EN
    applyStimulus("SW100s", 1'b1, 1'b0, 2'b10, 32'h100, 32'h44332211, 0, 32'h0, 1'b0, 4'd0, 2, 1);
    applyStimulus("SW104s", 1'b1, 1'b0, 2'b10, 32'h104, 32'h88776655, 0, 32'h0, 1'b0, 4'd0, 2, 1);
    applyStimulus("SW108s", 1'b1, 1'b0, 2'b10, 32'h108, 32'h000000FF, 0, 32'h0, 1'b0, 4'd0, 2, 1);
    applyStimulus("LW102split", 1'b0, 1'b0, 2'b10, 32'h102, 32'h0, 0, 32'h66554433, 1'b0, 4'd0, 3, 2);
    applyStimulus("LH103split", 1'b0, 1'b0, 2'b01, 32'h103, 32'h0, 0, 32'h00005544, 1'b0, 4'd0, 3, 2);
    applyStimulus("LH107signed", 1'b0, 1'b1, 2'b01, 32'h107, 32'h0, 0, 32'hFFFFFF88, 1'b0, 4'd0, 3, 2);
    applyStimulus("SW102split", 1'b1, 1'b0, 2'b10, 32'h102, 32'h1, 0, 32'h0, 1'b1, 4'd6, 1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
